adc_sample_fifo: RTL and testbench
==================================

Name: adc_sample_fifo

Overview:
- Sits directly downstream of the ADC-side serial-to-parallel deserializer.
- Synchronises the slow sample clock into the fast-clock domain and captures each completed 16-bit word once per sample period.
- Queues captured words in a small first-word-fall-through FIFO.
- Presents the words to the DSP/DAC path on a valid/ready handshake, with sticky overflow reporting.

Parameters:
- WIDTH, 16, sample word width in bits.
- DEPTH, 4, FIFO depth in words. Must be a power of 2 and at least 2.
- SYNC_STAGES, 2, flop stages in the slow_clock synchroniser. Must be at least 2.

Ports:
- clk  in  1  fast clock, same clock as the deserializer.
- reset  in  1  reset, synchronous, active-high.
- slow_clock  in  1  sample clock, asynchronous to clk.
- sample_in  in  WIDTH  parallel word from the deserializer. Stable around each slow_clock rising edge.
- enable  in  1  1 = captures allowed.
- out_data  out  WIDTH  head-of-FIFO word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- count  out  clog2(DEPTH)+1  words currently stored.
- overflow  out  1  sticky; set when a capture is dropped.
- drop_count  out  8  saturating count of dropped captures.
- clr_status  in  1  clears overflow and drop_count.

Behaviour:
- Reset (synchronous, active-high):
  - rd/wr pointers, count, overflow and drop_count go to 0. FIFO contents are discarded.
  - out_valid goes to 0. out_data is don't-care while out_valid=0.
  - All synchroniser flops and the edge-detect "prev" flop load 1. A slow_clock held high through reset release therefore produces no capture; the first capture needs slow_clock seen low, then high.
  - Reset mid-operation (FIFO non-empty or capture in flight) follows the same rule: state is fully cleared and the pending capture is lost, with no drop counted.
- Edge detect:
  - rise = sync_last & ~prev, where prev is sync_last delayed one clk.
  - rise is a single-cycle pulse per slow_clock rising edge.
- Latency (SYNC_STAGES=2):
  - slow_clock first sampled high at edge N gives rise high during the cycle after edge N+1.
  - The word is written at edge N+2, using the sample_in value sampled at edge N+2.
  - out_valid is high after edge N+2 if the FIFO was empty.
  - Each additional sync stage adds 1 cycle.
- Capture request: cap = rise & enable. When enable=0 the rise is ignored, not written and not counted as a drop.
- Pop: pop = out_valid & out_ready. The consumer may hold out_ready high permanently.
- Write rules:
  - Word is written when cap and (count<DEPTH, or pop in the same cycle).
  - Full with cap and pop in the same cycle: write and pop both occur, count stays DEPTH, data order is preserved.
  - Full with cap and no pop: the word is dropped, overflow is set to 1, drop_count increments and saturates at 255. Stored data is unchanged.
- Count: updates +1 on write only, −1 on pop only, unchanged on both or neither.
- Empty behaviour: out_valid=0, so pop cannot occur and out_ready is ignored.
  - Empty with cap: out_valid rises the next cycle.
  - There is no same-cycle bypass.
- Output timing: first-word-fall-through. out_data = mem[rd_ptr] whenever out_valid=1. out_valid = (count!=0).
- Pointers: wrap modulo DEPTH. count distinguishes full from empty.
- clr_status:
  - Clears overflow and drop_count at the next edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- Clock relationship: slow_clock period must exceed SYNC_STAGES+3 clk cycles. Faster sample clocks are unsupported; behaviour is undefined.

Test Plan:
- Reset release with slow_clock held high, then low for 5 cycles, then high with sample_in=16'hA5A5 → no word before the low phase; exactly one word 16'hA5A5 with out_valid high 3 cycles after slow_clock high; count=1.
- out_ready=0, 5 slow_clock periods with samples 16'h0001..16'h0005 → count=4, overflow=1, drop_count=1. Then out_ready=1 → pops 0001,0002,0003,0004 in order and out_valid falls.
- FIFO full and out_ready=1 aligned so a pop coincides with the write of 16'h00FF → count stays 4, overflow stays 0, 16'h00FF exits last.
- enable=0 across 3 slow_clock edges → count=0, drop_count=0. Set enable=1 on the next edge → 1 word captured.
- Force 300 drops, then pulse clr_status in the same cycle as a further drop → drop_count reads 255 before the pulse, then overflow=1 and drop_count=1.
- Assert reset mid-stream with count=3 and a rise pending → after release count=0 and out_valid=0; the pending word never appears.

Source files
------------

// File: rtl/adc_sample_fifo.sv
// ADC sample capture FIFO: synchronises slow_clock, captures one word per sample
// period into a small first-word-fall-through FIFO with sticky overflow reporting.
module adc_sample_fifo #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       slow_clock,
    input  logic [WIDTH-1:0]           sample_in,
    input  logic                       enable,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drop_count,
    input  logic                       clr_status
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_next;
    logic                   valid_q;
    logic                   overflow_q;
    logic [7:0]             drop_q;
    logic [WIDTH-1:0]       mem [DEPTH];

    logic sync_last;
    logic rise;
    logic cap;
    logic pop;
    logic full;
    logic wr_en;
    logic drop;

    // Capture/pop decisions for the current cycle
    always_comb begin
        sync_last  = sync_q[SYNC_STAGES-1];
        rise       = sync_last & ~prev_q;
        cap        = rise & enable;
        pop        = valid_q & out_ready;
        full       = (count_q == CW'(DEPTH));
        wr_en      = cap & (~full | pop);
        drop       = cap & full & ~pop;
        count_next = count_q;
        if (wr_en && !pop) begin
            count_next = count_q + CW'(1);
        end else if (pop && !wr_en) begin
            count_next = count_q - CW'(1);
        end
    end

    // Synchroniser and "prev" load 1 so a high slow_clock at release is not an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '1;
            prev_q     <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= 8'd0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], slow_clock};
            prev_q   <= sync_last;
            count_q  <= count_next;
            valid_q  <= (count_next != '0);
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            // A drop coinciding with clr_status restarts the count at one
            if (drop) begin
                overflow_q <= 1'b1;
                if (clr_status) begin
                    drop_q <= 8'd1;
                end else if (drop_q != 8'hFF) begin
                    drop_q <= drop_q + 8'd1;
                end
            end else if (clr_status) begin
                overflow_q <= 1'b0;
                drop_q     <= 8'd0;
            end
        end
    end

    // Storage needs no reset; count/valid gate what is visible
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= sample_in;
        end
    end

    assign out_data   = mem[rd_ptr_q];
    assign out_valid  = valid_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Scoreboard bench for adc_sample_fifo: directed sample periods, popped words
// checked against an expected-word queue by an independent monitor.
module tb_adc_sample_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        slow_clock;
    logic [15:0] sample_in;
    logic        enable;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        clr_status;

    int tests = 0;
    int fails = 0;
    logic [15:0] sb_q[$];

    adc_sample_fifo #(.WIDTH(16), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .slow_clock (slow_clock),
        .sample_in  (sample_in),
        .enable     (enable),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clr_status (clr_status)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One slow_clock period: 4 cycles low, 4 high; the write lands on the 3rd high cycle
    task automatic period(input logic [15:0] w, input bit exp_write);
        slow_clock = 1'b0;
        sample_in  = w;
        repeat (4) step();
        slow_clock = 1'b1;
        if (exp_write) sb_q.push_back(w);
        repeat (4) step();
    endtask

    // Monitor: every accepted word must match the head of the expected queue
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got %0h expected none", out_data);
            end else begin
                check("pop_data", {16'd0, out_data}, {16'd0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        reset      = 1'b1;
        slow_clock = 1'b1;
        sample_in  = 16'd0;
        enable     = 1'b1;
        out_ready  = 1'b0;
        clr_status = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        // Reset release with slow_clock held high: no capture
        repeat (5) step();
        check("t1_rst_count", 32'(count), 32'd0);
        check("t1_rst_valid", 32'(out_valid), 32'd0);
        check("t1_rst_ovf", 32'(overflow), 32'd0);
        check("t1_rst_drops", 32'(drop_count), 32'd0);
        slow_clock = 1'b0;
        sample_in  = 16'hA5A5;
        repeat (5) step();
        sb_q.push_back(16'hA5A5);
        slow_clock = 1'b1;
        step();
        step();
        check("t1_valid_early", 32'(out_valid), 32'd0);
        step();
        check("t1_valid_3cyc", 32'(out_valid), 32'd1);
        check("t1_count", 32'(count), 32'd1);
        check("t1_data", 32'(out_data), 32'h0000A5A5);
        step();
        out_ready = 1'b1;
        repeat (4) step();
        check("t1_drained", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Overfill: 5 samples into depth 4
        for (int i = 1; i <= 5; i++) period(16'(i), i <= 4);
        check("t2_count", 32'(count), 32'd4);
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_drops", 32'(drop_count), 32'd1);
        out_ready = 1'b1;
        repeat (8) step();
        check("t2_empty_count", 32'(count), 32'd0);
        check("t2_empty_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Full FIFO with a pop coinciding with the write
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check("t3_clr_ovf", 32'(overflow), 32'd0);
        check("t3_clr_drops", 32'(drop_count), 32'd0);
        for (int i = 0; i < 4; i++) period(16'(16'h10 + i), 1'b1);
        slow_clock = 1'b0;
        sample_in  = 16'h00FF;
        repeat (4) step();
        slow_clock = 1'b1;
        sb_q.push_back(16'h00FF);
        step();
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t3_count_full", 32'(count), 32'd4);
        check("t3_ovf", 32'(overflow), 32'd0);
        check("t3_drops", 32'(drop_count), 32'd0);
        step();
        out_ready = 1'b1;
        repeat (8) step();
        check("t3_empty", 32'(count), 32'd0);
        out_ready = 1'b0;

        // enable=0 ignores edges without counting drops
        enable = 1'b0;
        for (int i = 0; i < 3; i++) period(16'h0BAD, 1'b0);
        check("t4_count", 32'(count), 32'd0);
        check("t4_drops", 32'(drop_count), 32'd0);
        enable = 1'b1;
        period(16'h0E0E, 1'b1);
        check("t4_one_word", 32'(count), 32'd1);
        out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;

        // Saturating drop counter and clr_status racing a drop
        for (int i = 0; i < 4; i++) period(16'(16'h50 + i), 1'b1);
        for (int i = 0; i < 300; i++) period(16'(16'h100 + i), 1'b0);
        check("t5_drops_sat", 32'(drop_count), 32'd255);
        check("t5_ovf", 32'(overflow), 32'd1);
        slow_clock = 1'b0;
        sample_in  = 16'hDEAD;
        repeat (4) step();
        slow_clock = 1'b1;
        step();
        step();
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check("t5_clr_drop_ovf", 32'(overflow), 32'd1);
        check("t5_clr_drop_cnt", 32'(drop_count), 32'd1);
        step();
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check("t5_clr_ovf", 32'(overflow), 32'd0);
        check("t5_clr_cnt", 32'(drop_count), 32'd0);
        out_ready = 1'b1;
        repeat (8) step();
        check("t5_empty", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Reset mid-stream with three words stored and a rise pending
        for (int i = 1; i <= 3; i++) period(16'(16'h60 + i), 1'b0);
        check("t6_count3", 32'(count), 32'd3);
        slow_clock = 1'b0;
        sample_in  = 16'h0064;
        repeat (4) step();
        slow_clock = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_count", 32'(count), 32'd0);
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_drops", 32'(drop_count), 32'd0);
        repeat (4) step();
        out_ready = 1'b1;
        repeat (4) step();
        check("t6_still_empty", 32'(out_valid), 32'd0);
        check("t6_still_count", 32'(count), 32'd0);

        check("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
